// File: rtl/counter_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// counter_cmd_seq_if
// Command push channel into the counter command sequencer.
//   cmd_valid_i : producer has a command on cmd_op_i / cmd_arg_i
//   cmd_ready_o : sequencer FIFO can take it (push on valid && ready)
//   cmd_op_i    : 00 NOP, 01 LOAD, 10 RUN, 11 HOLD
//   cmd_arg_i   : LOAD value (low bits) or RUN/HOLD cycle count
// Modports: master = command producer, slave = sequencer.
// ---------------------------------------------------------------------------
interface counter_cmd_seq_if #(
  parameter int LEN_W = 8
) ();
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [1:0]       cmd_op_i;
  logic [LEN_W-1:0] cmd_arg_i;

  modport master (
    output cmd_valid_i,
    output cmd_op_i,
    output cmd_arg_i,
    input  cmd_ready_o
  );

  modport slave (
    input  cmd_valid_i,
    input  cmd_op_i,
    input  cmd_arg_i,
    output cmd_ready_o
  );
endinterface

// File: rtl/counter_cmd_seq.sv
// ---------------------------------------------------------------------------
// counter_cmd_seq
// Command sequencer feeding a DATA_W-bit counter. Commands pushed over the
// cmd interface are queued in a DEPTH-entry FIFO and replayed as an exact,
// bubble-free pattern on enable_o / load_o / data_o.
// Ports:
//   clk_i     : clock, rising edge
//   rst_n_i   : asynchronous active-low reset
//   flush_i   : synchronous flush of queued and active commands
//   cmd       : command channel (slave modport of counter_cmd_seq_if)
//   enable_o  : counter enable
//   load_o    : counter load strobe
//   data_o    : counter load value, held between LOADs
//   busy_o    : command executing or FIFO non-empty
//   level_o   : FIFO occupancy
// ---------------------------------------------------------------------------
module counter_cmd_seq #(
  parameter int DATA_W = 4,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  counter_cmd_seq_if.slave         cmd,
  output logic                     enable_o,
  output logic                     load_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               enable_d, load_d;
  logic [DATA_W-1:0]  data_d;

  logic [1:0]         op_mem  [DEPTH];
  logic [LEN_W-1:0]   arg_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     level_q;

  logic               push, pop;
  logic [1:0]         head_op;
  logic [LEN_W-1:0]   head_arg;

  // Ready ignores any pop in the same cycle: a full FIFO never accepts.
  assign cmd.cmd_ready_o = (level_q < (PTR_W+1)'(DEPTH)) && !flush_i;
  assign push            = cmd.cmd_valid_i && cmd.cmd_ready_o;

  // The head is taken either when idle or on the final cycle of the
  // running command, so the next command starts with no bubble.
  assign pop = !flush_i && (level_q != '0) &&
               ((state_q == IDLE) || (rem_q == LEN_W'(1)));

  assign head_op  = op_mem[rd_ptr_q];
  assign head_arg = arg_mem[rd_ptr_q];

  assign level_o = level_q;
  assign busy_o  = (state_q == EXEC) || (level_q != '0);

  // FIFO storage has no reset; only the pointers and level define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      op_mem[wr_ptr_q]  <= cmd.cmd_op_i;
      arg_mem[wr_ptr_q] <= cmd.cmd_arg_i;
    end
  end

  // FIFO pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + (PTR_W+1)'(1);
        2'b01:   level_q <= level_q - (PTR_W+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Execution state and registered counter-side outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      enable_o <= 1'b0;
      load_o   <= 1'b0;
      data_o   <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      enable_o <= enable_d;
      load_o   <= load_d;
      data_o   <= data_d;
    end
  end

  // Next-state decode. Every command lasts at least one cycle, so rem is
  // loaded with 1 for LOAD, NOP and zero-length RUN/HOLD. data_o is only
  // ever changed by a LOAD.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    enable_d = enable_o;
    load_d   = load_o;
    data_d   = data_o;

    if (flush_i) begin
      state_d  = IDLE;
      rem_d    = '0;
      enable_d = 1'b0;
      load_d   = 1'b0;
    end else if (pop) begin
      state_d  = EXEC;
      rem_d    = LEN_W'(1);
      enable_d = 1'b0;
      load_d   = 1'b0;
      case (head_op)
        OP_LOAD: begin
          enable_d = 1'b1;
          load_d   = 1'b1;
          data_d   = head_arg[DATA_W-1:0];
        end
        OP_RUN: begin
          if (head_arg != '0) begin
            enable_d = 1'b1;
            rem_d    = head_arg;
          end
        end
        OP_HOLD: begin
          if (head_arg != '0) begin
            rem_d = head_arg;
          end
        end
        OP_NOP:  begin
          rem_d = LEN_W'(1);
        end
        default: begin
          rem_d = LEN_W'(1);
        end
      endcase
    end else if (state_q == EXEC) begin
      if (rem_q == LEN_W'(1)) begin
        state_d  = IDLE;
        rem_d    = '0;
        enable_d = 1'b0;
        load_d   = 1'b0;
      end else begin
        rem_d = rem_q - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_counter_cmd_seq
// Directed bench for counter_cmd_seq. A small 4-bit counter model sits on
// the sequencer outputs so counter-level results can be checked. Per-cycle
// traces of enable/load/busy/count are captured on the falling edge and
// compared against hand-computed bit patterns (earliest cycle in the MSB).
// ---------------------------------------------------------------------------
module tb_counter_cmd_seq;

  localparam int DATA_W = 4;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 4;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              enable;
  logic              load;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic [2:0]        level;

  logic [3:0]        cnt;

  logic [31:0]       en_hist;
  logic [31:0]       ld_hist;
  logic [31:0]       busy_hist;
  logic [31:0]       cnt_hist;

  int compared   = 0;
  int mismatched = 0;
  int wait_cycles;

  counter_cmd_seq_if #(.LEN_W(LEN_W)) cmd_if ();

  counter_cmd_seq #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .cmd     (cmd_if),
    .enable_o(enable),
    .load_o  (load),
    .data_o  (data),
    .busy_o  (busy),
    .level_o (level)
  );

  always #5 clk = ~clk;

  // Downstream 4-bit counter model driven by the sequencer outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'h0;
    end else if (enable && load) begin
      cnt <= data;
    end else if (enable) begin
      cnt <= cnt + 4'h1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push one command; called just after a rising edge, returns just after
  // the edge at which it was accepted.
  task automatic pushCmd(input logic [1:0] op, input logic [LEN_W-1:0] arg);
    logic accepted;
    accepted = 1'b0;
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_op_i    = op;
    cmd_if.cmd_arg_i   = arg;
    for (int i = 0; i < 64 && !accepted; i++) begin
      accepted = cmd_if.cmd_ready_o;
      @(posedge clk);
      #1;
    end
    cmd_if.cmd_valid_i = 1'b0;
    if (!accepted) begin
      checkOutput("push_timeout", 32'd0, 32'd1);
    end
  endtask

  // Capture n cycles, one sample on the falling edge after each rising edge.
  task automatic traceRun(input int n);
    en_hist   = '0;
    ld_hist   = '0;
    busy_hist = '0;
    cnt_hist  = '0;
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en_hist   = {en_hist[30:0], enable};
      ld_hist   = {ld_hist[30:0], load};
      busy_hist = {busy_hist[30:0], busy};
      cnt_hist  = {cnt_hist[27:0], cnt};
    end
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      step(1);
      n++;
    end
    if (busy) begin
      checkOutput("idle_timeout", 32'd1, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cmd_if.cmd_valid_i = 1'b0;
    cmd_if.cmd_op_i    = OP_NOP;
    cmd_if.cmd_arg_i   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_enable", enable, 1'b0);
    checkOutput("rst_load", load, 1'b0);
    checkOutput("rst_data", data, 4'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_level", level, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    checkOutput("rst_ready", cmd_if.cmd_ready_o, 1'b1);

    // LOAD 0xA (upper arg bits set, must be ignored) then RUN 5
    $display("[TB] LOAD 0xA, RUN 5");
    fork
      traceRun(12);
      begin
        pushCmd(OP_LOAD, 8'h3A);
        pushCmd(OP_RUN, 8'd5);
      end
    join
    checkOutput("lr_enable_trace", en_hist, 32'h7E0);
    checkOutput("lr_load_trace", ld_hist, 32'h400);
    checkOutput("lr_busy_trace", busy_hist, 32'hFE0);
    checkOutput("lr_count", cnt, 4'hF);
    checkOutput("lr_even", {3'b0, ~cnt[0]}, 4'h0);
    checkOutput("lr_data", data, 4'hA);
    step(1);

    // HOLD 3 then RUN 2
    $display("[TB] HOLD 3, RUN 2");
    fork
      traceRun(10);
      begin
        pushCmd(OP_HOLD, 8'd3);
        pushCmd(OP_RUN, 8'd2);
      end
    join
    checkOutput("hr_enable_trace", en_hist, 32'h030);
    checkOutput("hr_busy_trace", busy_hist, 32'h3F0);
    step(1);

    // Single-cycle commands: RUN 0, NOP, HOLD 0
    $display("[TB] RUN 0 / NOP / HOLD 0");
    fork
      traceRun(6);
      pushCmd(OP_RUN, 8'd0);
    join
    checkOutput("run0_enable_trace", en_hist, 32'h00);
    checkOutput("run0_busy_trace", busy_hist, 32'h30);
    step(1);
    fork
      traceRun(6);
      pushCmd(OP_NOP, 8'd7);
    join
    checkOutput("nop_enable_trace", en_hist, 32'h00);
    checkOutput("nop_busy_trace", busy_hist, 32'h30);
    step(1);
    fork
      traceRun(6);
      pushCmd(OP_HOLD, 8'd0);
    join
    checkOutput("hold0_busy_trace", busy_hist, 32'h30);
    step(1);

    // Mixed LOAD 3, RUN 0, RUN 1
    $display("[TB] LOAD 3, RUN 0, RUN 1");
    fork
      traceRun(10);
      begin
        pushCmd(OP_LOAD, 8'd3);
        pushCmd(OP_RUN, 8'd0);
        pushCmd(OP_RUN, 8'd1);
      end
    join
    checkOutput("mix_enable_trace", en_hist, 32'h140);
    checkOutput("mix_load_trace", ld_hist, 32'h100);
    checkOutput("mix_busy_trace", busy_hist, 32'h3C0);
    checkOutput("mix_count", cnt, 4'h4);
    step(1);

    // Wrap-around: LOAD 0xE then RUN 3, counter starts at 4
    $display("[TB] LOAD 0xE, RUN 3");
    fork
      traceRun(8);
      begin
        pushCmd(OP_LOAD, 8'h0E);
        pushCmd(OP_RUN, 8'd3);
      end
    join
    checkOutput("wrap_count_trace", cnt_hist, 32'h44EF0111);
    checkOutput("wrap_enable_trace", en_hist, 32'h78);
    step(1);

    // Fill FIFO behind RUN 20; fifth push stalls until the next pop
    $display("[TB] FIFO full behind RUN 20");
    pushCmd(OP_RUN, 8'd20);
    for (int i = 0; i < DEPTH; i++) begin
      pushCmd(OP_NOP, 8'd0);
    end
    checkOutput("full_level", level, 3'd4);
    checkOutput("full_ready", cmd_if.cmd_ready_o, 1'b0);
    checkOutput("full_enable", enable, 1'b1);
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_op_i    = OP_NOP;
    cmd_if.cmd_arg_i   = '0;
    wait_cycles = 0;
    while (!cmd_if.cmd_ready_o && wait_cycles < 40) begin
      step(1);
      wait_cycles++;
    end
    checkOutput("full_ready_wait", wait_cycles, 32'd17);
    checkOutput("full_level_after_pop", level, 3'd3);
    step(1);
    cmd_if.cmd_valid_i = 1'b0;
    checkOutput("full_level_push_pop", level, 3'd3);
    waitIdle();
    step(1);

    // Flush during RUN 50 with two queued commands and a colliding push
    $display("[TB] flush during RUN 50");
    pushCmd(OP_RUN, 8'd50);
    pushCmd(OP_NOP, 8'd0);
    pushCmd(OP_NOP, 8'd0);
    checkOutput("flush_pre_level", level, 3'd2);
    checkOutput("flush_pre_enable", enable, 1'b1);
    flush = 1'b1;
    cmd_if.cmd_valid_i = 1'b1;
    cmd_if.cmd_op_i    = OP_LOAD;
    cmd_if.cmd_arg_i   = 8'h05;
    #1;
    checkOutput("flush_ready", cmd_if.cmd_ready_o, 1'b0);
    step(1);
    flush = 1'b0;
    cmd_if.cmd_valid_i = 1'b0;
    checkOutput("flush_enable", enable, 1'b0);
    checkOutput("flush_load", load, 1'b0);
    checkOutput("flush_level", level, 3'd0);
    checkOutput("flush_busy", busy, 1'b0);
    checkOutput("flush_data", data, 4'hE);
    step(3);
    checkOutput("flush_after_enable", enable, 1'b0);
    checkOutput("flush_after_busy", busy, 1'b0);

    // Asynchronous reset in the middle of RUN 10 after three enable cycles
    $display("[TB] reset during RUN 10");
    pushCmd(OP_RUN, 8'd10);
    pushCmd(OP_NOP, 8'd0);
    step(2);
    checkOutput("mid_enable", enable, 1'b1);
    checkOutput("mid_level", level, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_enable", enable, 1'b0);
    checkOutput("arst_level", level, 3'd0);
    checkOutput("arst_data", data, 4'h0);
    checkOutput("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    checkOutput("post_rst_busy", busy, 1'b0);
    checkOutput("post_rst_enable", enable, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/counter_cmd_seq.md
Name: counter_cmd_seq

Overview:
Command sequencer that sits directly upstream of the 4-bit counter and drives its enable/load/data inputs. Testbench or software pushes commands (LOAD, RUN n, HOLD n, NOP) over a valid/ready interface into a small FIFO. An execution FSM turns each command into an exact cycle-accurate pattern on enable_o/load_o/data_o. This makes counter stimulus deterministic and back-to-back, with no bubbles between commands.

Parameters:
DATA_W, 4, width of data_o and of the LOAD value; matches counter width
LEN_W, 8, width of cmd_arg_i; also the RUN/HOLD cycle count
DEPTH, 4, command FIFO entries; power of 2, ≥2

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  reset, asynchronous, active-low
flush_i  input  1  synchronous flush: drop queued and active commands
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  FIFO can accept; push on valid&&ready at rising edge
cmd_op_i  input  2  00 NOP, 01 LOAD, 10 RUN, 11 HOLD
cmd_arg_i  input  LEN_W  LOAD: value in [DATA_W-1:0]; RUN/HOLD: cycle count
enable_o  output  1  to counter enable_i
load_o  output  1  to counter load_i
data_o  output  DATA_W  to counter data_i
busy_o  output  1  command executing or FIFO non-empty
level_o  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- One clock (clk_i). Reset is asynchronous and active-low (rst_n_i). All state is clk_i-domain.
- Reset: FIFO empty, level_o=0, FSM=IDLE, enable_o=0, load_o=0, data_o=0, busy_o=0. Reset mid-command aborts it immediately; enable_o drops asynchronously.
- cmd_ready_o = (level < DEPTH) && !flush_i, combinational. No push-through when full, even if a pop occurs in the same cycle.
- FIFO: push and pop in the same cycle leave level_o unchanged. Commands retire in strict order.
- FSM states: IDLE, EXEC. A per-command down-counter rem, LEN_W bits wide, tracks remaining cycles.
- Pop rule: pop the head at the rising edge where FIFO is non-empty and either (a) FSM=IDLE or (b) FSM=EXEC with rem==1, meaning the last cycle of the current command.
  - Pop takes the FSM to EXEC and loads outputs and rem in that same edge.
  - Result: zero bubble between consecutive commands.
- If no pop occurs at the end of a command, the FSM goes to IDLE and enable_o=0, load_o=0.
- Latency: a command pushed at edge N into an idle, empty sequencer drives its outputs from edge N+1.
- Outputs are registered. Per command:
  - LOAD: 1 cycle of enable_o=1, load_o=1, data_o=arg[DATA_W-1:0]. Upper arg bits are ignored.
  - RUN k: k cycles of enable_o=1, load_o=0.
  - HOLD k: k cycles of enable_o=0, load_o=0.
  - NOP: 1 cycle of enable_o=0, load_o=0.
  - RUN 0 and HOLD 0 behave as NOP (1 cycle, enable_o=0).
- data_o retains the last LOAD value until the next LOAD. Only reset clears it; flush does not.
- flush_i=1 at an edge:
  - FIFO is emptied and FSM goes to IDLE.
  - enable_o and load_o are 0 from that edge onward.
  - A simultaneous push is dropped, since ready is low.
  - A simultaneous pop is suppressed.
- busy_o = (FSM==EXEC) || (level_o != 0), registered-equivalent timing.

Test Plan:
- Reset mid-RUN 10 after 3 enable cycles: rst_n_i low → enable_o=0 immediately, level_o=0, data_o=0. After release, busy_o stays 0.
- Push LOAD 0xA, then RUN 5, back-to-back:
  - 1 cycle enable=1, load=1, data=0xA, then 5 cycles enable=1, load=0, then idle.
  - Counter reads 0xF after the 5th RUN cycle, with even_o=0.
- Push HOLD 3 then RUN 2: enable_o low for exactly 3 cycles, then high for exactly 2, with no gap or extra cycle.
- Push DEPTH+1 commands while a RUN 20 executes: cmd_ready_o=0 once level_o=4, and the 5th push stalls. Ready reasserts the cycle after the next pop.
- RUN 0 and NOP: each occupies exactly 1 cycle with enable_o=0. Ordering is preserved in a mixed sequence LOAD 3, RUN 0, RUN 1 (counter ends at 4).
- Wrap-around: LOAD 0xE then RUN 3 → the counter sequence seen is 0xE, 0xF, 0x0, 0x1. Separately, flush_i during RUN 50 with 2 queued commands gives enable_o=0 next cycle, level_o=0, and data_o unchanged.
